// File: rtl/lmsm_sequencer.sv
// LM/SM micro-sequencer: emits one register transfer per handshake for multi-register load/store.
// Ports: clk, reset (sync, active-high), ir_valid, ir, base_addr, stall_in -> hold_fetch, seq_valid,
//   seq_reg, seq_addr, wRF, wMem (active-low), done; flush input present only with LMSM_FLUSH_EN.
module lmsm_sequencer #(
   parameter int ADDR_W = 16,
   parameter int MASK_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ir_valid,
   input  logic [15:0]       ir,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              stall_in,
`ifdef LMSM_FLUSH_EN
   input  logic              flush,
`endif
   output logic              hold_fetch,
   output logic              seq_valid,
   output logic [2:0]        seq_reg,
   output logic [ADDR_W-1:0] seq_addr,
   output logic              wRF,
   output logic              wMem,
   output logic              done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [MASK_W-1:0] mask_q;
   logic [ADDR_W-1:0] addr_q;
   logic              is_load_q;
   logic              done_q;

   logic              flush_w;
   logic              is_lmsm;
   logic              accept;
   logic              fire;
   logic              run;
   logic [MASK_W-1:0] mask_nxt;
   logic [2:0]        low_idx;
   logic              unused_ir;

`ifdef LMSM_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   assign unused_ir = ^ir[11:8];

   // opcodes 0110 and 0111 share the top three bits
   assign is_lmsm = (ir[15:13] == 3'b011);
   assign run     = (state == RUN);
   assign accept  = (state == IDLE) & ir_valid & is_lmsm & ~flush_w;
   assign fire    = run & ~stall_in;

   // clears the lowest set bit, i.e. the transfer being presented
   assign mask_nxt = mask_q & (mask_q - 1'b1);

   always_comb begin
      low_idx = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (mask_q[i]) low_idx = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mask_q    <= '0;
         addr_q    <= '0;
         is_load_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mask_q    <= ir[MASK_W-1:0];
                  addr_q    <= base_addr;
                  is_load_q <= ~ir[12];
                  if (ir[MASK_W-1:0] != '0) state  <= RUN;
                  else                      done_q <= 1'b1;
               end
            end
            RUN: begin
               if (fire) begin
                  mask_q <= mask_nxt;
                  addr_q <= addr_q + 1'b1;
               end
               if (flush_w) begin
                  state  <= IDLE;
                  mask_q <= '0;
               end else if (fire && mask_nxt == '0) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // outputs sit at their reset values whenever no sequence is running
   assign hold_fetch = run | accept;
   assign seq_valid  = run;
   assign seq_reg    = run ? low_idx : 3'd0;
   assign seq_addr   = run ? addr_q : '0;
   assign wRF        = run ? ~is_load_q : 1'b1;
   assign wMem       = run ? is_load_q : 1'b1;
   assign done       = done_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Testbench for lmsm_sequencer: directed and randomized LM/SM sequences
// checked against a transfer-list reference model.
module tb_lmsm_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ir_valid;
   logic [15:0] ir;
   logic [15:0] base_addr;
   logic        stall_in;
   logic        flush;
   logic        hold_fetch;
   logic        seq_valid;
   logic [2:0]  seq_reg;
   logic [15:0] seq_addr;
   logic        wRF;
   logic        wMem;
   logic        done;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int          r;
      logic [15:0] a;
   } xfer_t;

   always #5 clk = ~clk;

   lmsm_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .ir_valid   (ir_valid),
      .ir         (ir),
      .base_addr  (base_addr),
      .stall_in   (stall_in),
`ifdef LMSM_FLUSH_EN
      .flush      (flush),
`endif
      .hold_fetch (hold_fetch),
      .seq_valid  (seq_valid),
      .seq_reg    (seq_reg),
      .seq_addr   (seq_addr),
      .wRF        (wRF),
      .wMem       (wMem),
      .done       (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, "_hold"}, 32'(hold_fetch), 0);
      chk({tag, "_valid"}, 32'(seq_valid), 0);
      chk({tag, "_reg"}, 32'(seq_reg), 0);
      chk({tag, "_addr"}, 32'(seq_addr), 0);
      chk({tag, "_wrf"}, 32'(wRF), 1);
      chk({tag, "_wmem"}, 32'(wMem), 1);
      chk({tag, "_done"}, 32'(done), 32'(exp_done));
   endtask

   // mode 0: no stalls, 1: random stalls, 2: three stalls on first transfer
   task automatic run_seq(input logic [15:0] iw, input logic [15:0] base,
                          input int mode);
      xfer_t       q[$];
      logic [15:0] a;
      logic        ld;
      int          st;
      int          cyc;
      int          nx;
      int          pc;
      a  = base;
      ld = (iw[15:12] == 4'b0110);
      st = 0;
      cyc = 0;
      nx = 0;
      pc = 0;
      for (int i = 0; i < 8; i++) begin
         if (iw[i]) begin
            q.push_back('{i, a});
            a = a + 16'd1;
            pc++;
         end
      end
      @(negedge clk);
      ir_valid  = 1'b1;
      ir        = iw;
      base_addr = base;
      stall_in  = 1'b0;
      #1;
      chk("acc_hold", 32'(hold_fetch), 1);
      chk("acc_valid", 32'(seq_valid), 0);
      while (q.size() > 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         ir_valid  = 1'($urandom);
         ir        = 16'($urandom);
         base_addr = 16'($urandom);
         if (mode == 1)      stall_in = ($urandom_range(2) == 0);
         else if (mode == 2) stall_in = (st < 3);
         else                stall_in = 1'b0;
         if (stall_in) st++;
         #1;
         chk("run_valid", 32'(seq_valid), 1);
         chk("run_hold", 32'(hold_fetch), 1);
         chk("run_reg", 32'(seq_reg), 32'(q[0].r));
         chk("run_addr", 32'(seq_addr), 32'(q[0].a));
         chk("run_wrf", 32'(wRF), ld ? 0 : 1);
         chk("run_wmem", 32'(wMem), ld ? 1 : 0);
         chk("run_done", 32'(done), 0);
         if (!stall_in) begin
            void'(q.pop_front());
            nx++;
         end
      end
      chk("xfer_count", 32'(nx), 32'(pc));
      @(negedge clk);
      ir_valid = 1'b0;
      stall_in = 1'b0;
      #1;
      chk_idle("end", 1'b1);
      @(negedge clk);
      #1;
      chk("done_pulse", 32'(done), 0);
   endtask

   initial begin
      reset     = 1'b1;
      ir_valid  = 1'b0;
      ir        = '0;
      base_addr = '0;
      stall_in  = 1'b0;
      flush     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_idle("reset", 1'b0);
      reset = 1'b0;

      // non-LM/SM instruction is ignored
      @(negedge clk);
      ir_valid = 1'b1;
      ir       = 16'h1234;
      #1;
      chk("nonlm_hold", 32'(hold_fetch), 0);
      @(negedge clk);
      ir_valid = 1'b0;
      #1;
      chk_idle("nonlm", 1'b0);

      run_seq(16'h60A5, 16'h0100, 0);
      run_seq(16'h7080, 16'hFFFF, 0);
      run_seq(16'h7003, 16'hFFFF, 0);
      run_seq(16'h6000, 16'h1234, 0);
      run_seq(16'h6003, 16'h0200, 2);

      for (int k = 0; k < 8; k++) begin
         logic [15:0] iw;
         logic [15:0] b;
         iw = {3'b011, 1'($urandom), 4'($urandom), 8'($urandom)};
         b  = (k % 3 == 0) ? 16'hFFFC + 16'($urandom_range(3))
                           : 16'($urandom);
         run_seq(iw, b, 1);
      end

      // reset after 2 of 5 transfers
      @(negedge clk);
      ir_valid  = 1'b1;
      ir        = 16'h601F;
      base_addr = 16'h2000;
      #1;
      chk("rst_acc_hold", 32'(hold_fetch), 1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         ir_valid = 1'b0;
         #1;
         chk("rst_run_reg", 32'(seq_reg), 32'(i));
         chk("rst_run_addr", 32'(seq_addr), 32'h2000 + 32'(i));
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_idle("rst_mid", 1'b0);
      @(negedge clk);
      #1;
      chk_idle("rst_after", 1'b0);

`ifdef LMSM_FLUSH_EN
      begin
         int fires;
         fires = 0;
         @(negedge clk);
         ir_valid  = 1'b1;
         ir        = 16'h70FF;
         base_addr = 16'h0040;
         #1;
         chk("fl_acc_hold", 32'(hold_fetch), 1);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ir_valid = 1'b0;
            flush    = (i == 2);
            #1;
            chk("fl_reg", 32'(seq_reg), 32'(i));
            chk("fl_wmem", 32'(wMem), 0);
            if (seq_valid && !stall_in) fires++;
         end
         chk("fl_fires", 32'(fires), 3);
         @(negedge clk);
         flush = 1'b0;
         #1;
         chk_idle("fl_after", 1'b0);
         @(negedge clk);
         #1;
         chk("fl_no_done", 32'(done), 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
